// File: rtl/wm8731_cfg_seq_pkg.sv
// rtl/wm8731_cfg_seq_pkg.sv - shared types and constants for the WM8731 configuration sequencer
package wm8731_cfg_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_LOAD,
    ST_ISSUE,
    ST_GAP,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [6:0] REG_R0  = 7'h00;
  localparam logic [6:0] REG_R1  = 7'h01;
  localparam logic [6:0] REG_R2  = 7'h02;
  localparam logic [6:0] REG_R3  = 7'h03;
  localparam logic [6:0] REG_R4  = 7'h04;
  localparam logic [6:0] REG_R5  = 7'h05;
  localparam logic [6:0] REG_R6  = 7'h06;
  localparam logic [6:0] REG_R7  = 7'h07;
  localparam logic [6:0] REG_R8  = 7'h08;
  localparam logic [6:0] REG_R9  = 7'h09;
  localparam logic [6:0] REG_R15 = 7'h0F;

  localparam int         TABLE_LEN   = 11;
  localparam logic [3:0] LAST_IDX    = 4'(TABLE_LEN - 1);
  localparam logic [6:0] DEFAULT_VOL = 7'h79;

  // Codec control word: 7-bit register address above 9-bit register data.
  function automatic logic [15:0] cfg_word(input logic [6:0] addr, input logic [8:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/wm8731_cfg_seq_rom.sv
// rtl/wm8731_cfg_seq_rom.sv - combinational WM8731 register write table
module wm8731_cfg_rom
  import wm8731_cfg_seq_pkg::*;
(
  input  logic [3:0]  index,
  input  logic [6:0]  vol,
  output logic [15:0] word
);

  always_comb begin
    word = 16'h0000;
    case (index)
      4'd0:    word = cfg_word(REG_R15, 9'h000);
      4'd1:    word = cfg_word(REG_R6,  9'h000);
      4'd2:    word = cfg_word(REG_R0,  9'h017);
      4'd3:    word = cfg_word(REG_R1,  9'h017);
      // Headphone volume with zero-cross detect, sampled volume in the low bits.
      4'd4:    word = cfg_word(REG_R2,  {2'b01, vol});
      4'd5:    word = cfg_word(REG_R3,  {2'b01, vol});
      4'd6:    word = cfg_word(REG_R4,  9'h012);
      4'd7:    word = cfg_word(REG_R5,  9'h000);
      4'd8:    word = cfg_word(REG_R7,  9'h002);
      4'd9:    word = cfg_word(REG_R8,  9'h000);
      4'd10:   word = cfg_word(REG_R9,  9'h001);
      default: word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/wm8731_cfg_seq.sv
// rtl/wm8731_cfg_seq.sv - sequences the WM8731 register table out through an I2C write master
module wm8731_cfg_seq
  import wm8731_cfg_seq_pkg::*;
#(
  parameter int PWRUP_DLY = 50000,
  parameter int GAP_DLY   = 100,
  parameter int TIMEOUT   = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_start,
  input  logic [6:0] hp_vol,
  output logic [1:0] iic_start_sig,
  output logic [7:0] iic_addr,
  output logic [7:0] iic_wrdata,
  input  logic       iic_done,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic [3:0] cfg_index
);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  index_q, index_d;
  logic [6:0]  vol_q, vol_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wrdata_q, wrdata_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] rom_word;

  wm8731_cfg_rom u_rom (
    .index (index_q),
    .vol   (vol_q),
    .word  (rom_word)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    index_d  = index_q;
    vol_d    = vol_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    if (cfg_start) begin
      vol_d   = hp_vol;
      index_d = 4'd0;
      cnt_d   = 32'd0;
      state_d = ST_PWRUP;
    end else begin
      case (state_q)
        ST_IDLE: begin
          vol_d   = hp_vol;
          cnt_d   = 32'd0;
          state_d = ST_PWRUP;
        end
        ST_PWRUP: begin
          if (cnt_q == 32'(PWRUP_DLY - 1)) begin
            cnt_d   = 32'd0;
            state_d = ST_LOAD;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_LOAD: begin
          {addr_d, wrdata_d} = rom_word;
          cnt_d   = 32'd0;
          state_d = ST_ISSUE;
        end
        ST_ISSUE: begin
          // A completion on the final cycle still counts as success.
          if (iic_done) begin
            cnt_d   = 32'd0;
            state_d = (index_q == LAST_IDX) ? ST_DONE : ST_GAP;
          end else if (cnt_q == 32'(TIMEOUT - 1)) begin
            state_d = ST_ERR;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q == 32'(GAP_DLY - 1)) begin
            cnt_d   = 32'd0;
            index_d = index_q + 4'd1;
            state_d = ST_LOAD;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_DONE, ST_ERR: begin
          state_d = state_q;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Status flops follow the next state so outputs change together with it.
    start_d = (state_d == ST_ISSUE);
    busy_d  = (state_d == ST_PWRUP) || (state_d == ST_LOAD) ||
              (state_d == ST_ISSUE) || (state_d == ST_GAP);
    done_d  = (state_d == ST_DONE);
    err_d   = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 32'd0;
      index_q  <= 4'd0;
      vol_q    <= DEFAULT_VOL;
      addr_q   <= 8'h00;
      wrdata_q <= 8'h00;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      index_q  <= index_d;
      vol_q    <= vol_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign iic_start_sig = {1'b0, start_q};
  assign iic_addr      = addr_q;
  assign iic_wrdata    = wrdata_q;
  assign cfg_busy      = busy_q;
  assign cfg_done      = done_q;
  assign cfg_err       = err_q;
  assign cfg_index     = index_q;

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// tb/tb_wm8731_cfg_seq.sv - scoreboard bench for the WM8731 configuration sequencer
module tb_wm8731_cfg_seq;

  localparam int PWRUP = 10;
  localparam int GAP   = 4;
  localparam int TMO   = 200;

  localparam logic [15:0] TBL [11] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0480,
                                       16'h0680, 16'h0812, 16'h0A00, 16'h0E02, 16'h1000,
                                       16'h1201};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_start = 1'b0;
  logic [6:0] hp_vol = 7'h60;
  logic       iic_done = 1'b0;
  logic [1:0] iic_start_sig;
  logic [7:0] iic_addr;
  logic [7:0] iic_wrdata;
  logic       cfg_busy;
  logic       cfg_done;
  logic       cfg_err;
  logic [3:0] cfg_index;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] word;
  } wr_t;

  wr_t exp_q[$];
  int  pass_cnt = 0;
  int  total_cnt = 0;
  int  cyc = 0;
  int  ack_cnt = 0;
  bit  withhold = 1'b0;
  bit  prev_start = 1'b0;
  bit  chk_drop = 1'b0;
  int  last_done_cyc = -1000;
  int  last_wr_cyc = 0;
  bit  ok;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wm8731_cfg_seq #(.PWRUP_DLY(PWRUP), .GAP_DLY(GAP), .TIMEOUT(TMO)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .hp_vol        (hp_vol),
    .iic_start_sig (iic_start_sig),
    .iic_addr      (iic_addr),
    .iic_wrdata    (iic_wrdata),
    .iic_done      (iic_done),
    .cfg_busy      (cfg_busy),
    .cfg_done      (cfg_done),
    .cfg_err       (cfg_err),
    .cfg_index     (cfg_index)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic push_all(input logic [6:0] v);
    wr_t w;
    for (int i = 0; i < 11; i++) begin
      w.idx  = 4'(i);
      w.word = TBL[i];
      if (i == 4 || i == 5) w.word = w.word | {9'd0, v};
      exp_q.push_back(w);
    end
  endtask

  task automatic push_first(input int n);
    wr_t w;
    for (int i = 0; i < n; i++) begin
      w.idx  = 4'(i);
      w.word = TBL[i];
      exp_q.push_back(w);
    end
  endtask

  // I2C master model: acks 30 cycles into each write unless told to stall index 3.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      iic_done = 1'b0;
      if (iic_start_sig == 2'b01) begin
        ack_cnt++;
        if (ack_cnt == 30 && !(withhold && cfg_index == 4'd3)) iic_done = 1'b1;
      end else begin
        ack_cnt = 0;
      end
    end
  end

  // Monitor: handshake timing and write-order scoreboard.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (chk_drop) begin
        check("start_drop_after_done", iic_start_sig, 2'b00);
        chk_drop = 1'b0;
      end
      if (iic_done) begin
        check("start_held_at_done", iic_start_sig, 2'b01);
        last_done_cyc = cyc;
        chk_drop = 1'b1;
      end
      if (iic_start_sig == 2'b01 && !prev_start) begin
        last_wr_cyc = cyc;
        check("gap_before_write", (cyc - last_done_cyc) >= GAP + 2, 1);
        check("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("write_word", {iic_addr, iic_wrdata}, w.word);
          check("write_index", cfg_index, w.idx);
        end
      end
      prev_start = (iic_start_sig == 2'b01);
    end
  end

  initial begin
    // Reset state and full sequence with hp_vol = 60.
    repeat (3) @(negedge clk);
    check("rst_start", iic_start_sig, 2'b00);
    check("rst_addr", iic_addr, 8'h00);
    check("rst_wrdata", iic_wrdata, 8'h00);
    check("rst_flags", {cfg_busy, cfg_done, cfg_err}, 3'b000);
    check("rst_index", cfg_index, 4'd0);
    push_all(7'h60);
    check("tbl_idx4_vol60", exp_q[4].word, 16'h04E0);
    check("tbl_idx10", exp_q[10].word, 16'h1201);
    rst = 1'b0;
    @(negedge clk);
    check("busy_after_release", cfg_busy, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cfg_done) begin ok = 1'b1; break; end
    end
    check("seq1_done_reached", ok, 1'b1);
    check("seq1_flags", {cfg_busy, cfg_done, cfg_err}, 3'b010);
    check("seq1_index", cfg_index, 4'd10);
    check("seq1_start_idle", iic_start_sig, 2'b00);
    check("seq1_queue_empty", exp_q.size(), 0);

    // Timeout on index 3.
    withhold = 1'b1;
    hp_vol = 7'h21;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    check("restart_clears_done", cfg_done, 1'b0);
    push_first(4);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cfg_err) begin ok = 1'b1; break; end
    end
    check("seq2_err_reached", ok, 1'b1);
    check("seq2_timeout_len", cyc - last_wr_cyc, TMO);
    check("seq2_flags", {cfg_busy, cfg_done, cfg_err}, 3'b001);
    check("seq2_index", cfg_index, 4'd3);
    check("seq2_start_idle", iic_start_sig, 2'b00);
    repeat (50) @(negedge clk);
    check("seq2_err_holds", {cfg_err, cfg_index}, {1'b1, 4'd3});
    check("seq2_queue_empty", exp_q.size(), 0);
    withhold = 1'b0;

    // Restart during index 6 ISSUE with a new volume.
    hp_vol = 7'h33;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    check("restart_clears_err", cfg_err, 1'b0);
    push_all(7'h33);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cfg_index == 4'd6 && iic_start_sig == 2'b01) begin ok = 1'b1; break; end
    end
    check("seq3_reach_idx6", ok, 1'b1);
    repeat (5) @(negedge clk);
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    check("seq3_start_before_cancel", iic_start_sig, 2'b01);
    hp_vol = 7'h45;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    check("seq3_cancel_start", iic_start_sig, 2'b00);
    check("seq3_cancel_index", cfg_index, 4'd0);
    check("seq3_cancel_busy", cfg_busy, 1'b1);
    push_all(7'h45);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cfg_done) begin ok = 1'b1; break; end
    end
    check("seq3_done_reached", ok, 1'b1);
    check("seq3_queue_empty", exp_q.size(), 0);

    // Asynchronous reset in the GAP after index 2.
    hp_vol = 7'h10;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    push_all(7'h10);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (iic_done && cfg_index == 4'd2) begin ok = 1'b1; break; end
    end
    check("seq4_reach_idx2_done", ok, 1'b1);
    @(negedge clk);
    check("seq4_in_gap", {iic_start_sig, cfg_busy}, {2'b00, 1'b1});
    rst = 1'b1;
    #1;
    check("seq4_rst_start", iic_start_sig, 2'b00);
    check("seq4_rst_word", {iic_addr, iic_wrdata}, 16'h0000);
    check("seq4_rst_flags", {cfg_busy, cfg_done, cfg_err}, 3'b000);
    check("seq4_rst_index", cfg_index, 4'd0);
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    push_all(7'h10);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cfg_done) begin ok = 1'b1; break; end
    end
    check("seq4_done_reached", ok, 1'b1);
    check("seq4_index", cfg_index, 4'd10);
    check("seq4_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wm8731_cfg_seq.md
WM8731_CFG_SEQ -- requirements
Module: wm8731_cfg_seq

Interface
REQ-001 Parameter PWRUP_DLY, default 50000: clock cycles to wait after reset release or start, before the first write.
REQ-002 Parameter GAP_DLY, default 100: idle cycles inserted between consecutive I2C writes.
REQ-003 Parameter TIMEOUT, default 1000000: maximum cycles per write from issue to iic_done.
REQ-004 CLK  in  1  single clock for the whole block.
REQ-005 RST  in  1  reset, asynchronous and active-high.
REQ-006 cfg_start  in  1  one-cycle pulse; restarts the full configuration sequence.
REQ-007 hp_vol  in  7  headphone volume code; sampled on sequence start.
REQ-008 iic_start_sig  out  2  command to the I2C master; 2'b01 = write, 2'b00 = idle; 2'b10 is never driven.
REQ-009 iic_addr  out  8  upper byte of the codec word: {reg[6:0], data[8]}.
REQ-010 iic_wrdata  out  8  lower byte of the codec word: data[7:0].
REQ-011 iic_done  in  1  one-cycle completion pulse from the I2C master.
REQ-012 cfg_busy  out  1  high while the sequence runs.
REQ-013 cfg_done  out  1  level; high after all entries are written, until the next start.
REQ-014 cfg_err  out  1  level; high after a timeout, until the next start.
REQ-015 cfg_index  out  4  index of the current or last table entry.

Function
REQ-016 States SHALL be IDLE, PWRUP, LOAD, ISSUE, GAP, DONE and ERR.
REQ-017 Leaving reset, the FSM SHALL enter PWRUP automatically, with hp_vol sampled at that point.
REQ-018 A cfg_start pulse in any state SHALL resample hp_vol, clear cfg_done/cfg_err, set cfg_index=0 and enter PWRUP; a pulse during ISSUE first forces iic_start_sig=00.
REQ-019 PWRUP SHALL count PWRUP_DLY cycles, then go to LOAD.
REQ-020 LOAD SHALL register the 16-bit word for cfg_index onto iic_addr/iic_wrdata, then go to ISSUE one cycle later.
REQ-021 ISSUE SHALL drive iic_start_sig=01 from entry through the clock edge on which iic_done=1 is sampled, and SHALL drive 00 from the following cycle (registered).
  - The I2C master needs start held while it clears done.
REQ-022 iic_addr/iic_wrdata SHALL remain stable for the whole of ISSUE.
REQ-023 On iic_done, the FSM SHALL go to GAP.
  - If the entry was the last one (index 10), it goes to DONE instead.
REQ-024 GAP SHALL count GAP_DLY cycles, then increment cfg_index and go to LOAD.
REQ-025 A timeout counter SHALL clear on ISSUE entry.
  - Reaching TIMEOUT-1 without iic_done enters ERR: iic_start_sig=00, cfg_err=1, cfg_busy=0, cfg_index frozen.
REQ-026 In DONE, cfg_done=1, cfg_busy=0 and iic_start_sig=00; DONE and ERR SHALL hold until cfg_start or RST.
REQ-027 iic_done received outside ISSUE SHALL be ignored.
REQ-028 Table (16-bit words, index 0..10):
  - 0: 1E00
  - 1: 0C00
  - 2: 0017
  - 3: 0217
  - 4: 0480|vol
  - 5: 0680|vol
  - 6: 0812
  - 7: 0A00
  - 8: 0E02
  - 9: 1000
  - 10: 1201
  - vol is the sampled hp_vol, zero-extended to 16 bits.
REQ-029 cfg_busy SHALL be 1 exactly in PWRUP, LOAD, ISSUE and GAP.

Reset
REQ-030 On RST:
  - iic_start_sig=00, iic_addr=00, iic_wrdata=00
  - cfg_busy=0, cfg_done=0, cfg_err=0, cfg_index=0
  - all counters 0, sampled volume 7'h79
  - state IDLE, moving to PWRUP on the first clock after release
REQ-031 RST asserted mid-ISSUE SHALL drop iic_start_sig to 00 asynchronously.

Structure
REQ-032 A shared package SHALL hold:
  - the state encoding
  - the WM8731 register addresses (R0..R9, R15)
  - the table length constant (11)
  - the default volume (7'h79)
REQ-033 The table SHALL be one combinational sub-module, wm8731_cfg_rom (index and vol in, 16-bit word out); the FSM and counters stay in wm8731_cfg_seq.

Verification
REQ-034 Test parameters: PWRUP_DLY=10, GAP_DLY=4, TIMEOUT=200.
  - Bench I2C model acks each write with iic_done 30 cycles after iic_start_sig=01.
REQ-035 Reset release, hp_vol=7'h60 -> 11 writes in table order; index 4 gives addr=04, data=E0; index 10 gives addr=12, data=01; then cfg_done=1, cfg_busy=0.
REQ-036 Handshake: iic_done on cycle N -> iic_start_sig=01 at N and 00 at N+1; the next 01 does not appear before N+1+GAP_DLY+1.
REQ-037 Model withholds iic_done for index 3 -> cfg_err=1 after 200 cycles in ISSUE, cfg_index=3, iic_start_sig=00, no further writes.
REQ-038 cfg_start pulse during index 6 ISSUE -> iic_start_sig=00 next cycle, PWRUP restarts, first write after restart is 1E00 using the new hp_vol.
REQ-039 RST asserted mid-GAP -> all outputs at reset values immediately; the sequence re-runs from index 0 after release.
